// File: rtl/decode_scoreboard.sv
// decode_scoreboard: decode-stage issue controller.
// Chooses the candidate instruction from fetch or a one-entry replay buffer.
// Blocks consumers of in-flight loads with a per-register countdown
// scoreboard, and stretches a taken-branch flush over FLUSH_CYCLES cycles.
// Optional hazard/flush statistics are built when SCOREBOARD_STATS_EN is
// defined. Otherwise stall_cnt/flush_cnt are tied to zero.
module decode_scoreboard #(
   parameter int                 NUM_REGS     = 8,
   parameter int                 INSTR_W      = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR    = 16'h0800,
   parameter int                 LOAD_LAT     = 1,
   parameter int                 FLUSH_CYCLES = 2,
   localparam int                RW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   input  logic               stall,
   input  logic               flush,
   input  logic [NUM_REGS-1:0] cand_src_mask,
   input  logic               cand_is_load,
   input  logic [RW-1:0]      cand_dst,
   output logic [INSTR_W-1:0] cand_instr,
   output logic [INSTR_W-1:0] instr_out,
   output logic               issue,
   output logic               hazard,
   output logic               flush_out,
   output logic               fetch_hold,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        flush_cnt
);

   // Scoreboard entries count down from LOAD_LAT; the flush counter holds
   // the remaining window length after the flush cycle itself.
   localparam int SBW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
   localparam int FW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   logic [SBW-1:0]      sb [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [INSTR_W-1:0]  replay_instr;
   logic                replay_full;
   logic [FW-1:0]       flush_ctr;
   logic                cand_valid;

   // Candidate select and issue decision (single combinational path through the decoder)
   always_comb begin
      busy = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy[r] = |sb[r];
      end
      cand_instr = replay_full ? replay_instr : instr_in;
      cand_valid = replay_full | instr_valid;
      hazard     = cand_valid & |(cand_src_mask & busy);
      issue      = cand_valid & ~hazard & ~stall & ~flush & (flush_ctr == '0);
      instr_out  = issue ? cand_instr : NOP_INSTR;
      flush_out  = flush | (flush_ctr != '0);
   end

   assign fetch_hold = replay_full;

   // Load-use scoreboard: an issuing load reloads its entry, everything else counts down
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            sb[r] <= '0;
         end
      end else if (!stall) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (issue && cand_is_load && (cand_dst == RW'(r))) begin
               sb[r] <= SBW'(LOAD_LAT);
            end else if (sb[r] != '0) begin
               sb[r] <= sb[r] - SBW'(1);
            end
         end
      end
   end

   // Replay control and flush window; flush is captured even while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         replay_full <= 1'b0;
         flush_ctr   <= '0;
      end else if (flush) begin
         replay_full <= 1'b0;
         flush_ctr   <= FW'(FLUSH_CYCLES - 1);
      end else if (!stall) begin
         if (flush_ctr != '0) begin
            flush_ctr <= flush_ctr - FW'(1);
         end
         if (hazard && !replay_full) begin
            replay_full <= 1'b1;
         end else if (issue && replay_full) begin
            replay_full <= 1'b0;
         end
      end
   end

   // Replay data register: captures the blocked fetch instruction, no reset needed
   always_ff @(posedge clk) begin
      if (!stall && !flush && hazard && !replay_full) begin
         replay_instr <= instr_in;
      end
   end

`ifdef SCOREBOARD_STATS_EN
   logic [15:0] stall_q;
   logic [15:0] flush_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating statistics: unstalled hazard cycles and flush-assert cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'h0000;
         flush_q <= 16'h0000;
      end else begin
         if (!stall && hazard) begin
            stall_q <= sat_inc(stall_q);
         end
         if (flush) begin
            flush_q <= sat_inc(flush_q);
         end
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: table-driven bench for decode_scoreboard.
// Two instances share stimulus: u_dut (LOAD_LAT=1) and u_dut3 (LOAD_LAT=3).
// Test encoding decoded by the bench: bit15 = load, [10:8] = dst, [7:0] = src mask.
module tb_decode_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        stall;
   logic        flush;

   logic [7:0]  src_mask,  src_mask3;
   logic        is_load,   is_load3;
   logic [2:0]  dst,       dst3;
   logic [15:0] cand,      cand3;
   logic [15:0] out,       out3;
   logic        iss,       iss3;
   logic        haz,       haz3;
   logic        fo,        fo3;
   logic        hold,      hold3;
   logic [15:0] scnt,      scnt3;
   logic [15:0] fcnt,      fcnt3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_scoreboard #(.LOAD_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .stall(stall), .flush(flush), .cand_src_mask(src_mask),
      .cand_is_load(is_load), .cand_dst(dst), .cand_instr(cand),
      .instr_out(out), .issue(iss), .hazard(haz), .flush_out(fo),
      .fetch_hold(hold), .stall_cnt(scnt), .flush_cnt(fcnt)
   );

   decode_scoreboard #(.LOAD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .stall(stall), .flush(flush), .cand_src_mask(src_mask3),
      .cand_is_load(is_load3), .cand_dst(dst3), .cand_instr(cand3),
      .instr_out(out3), .issue(iss3), .hazard(haz3), .flush_out(fo3),
      .fetch_hold(hold3), .stall_cnt(scnt3), .flush_cnt(fcnt3)
   );

   // Bench-side decoders closing the cand_instr -> cand_* loop
   always_comb begin
      src_mask  = cand[7:0];
      is_load   = cand[15];
      dst       = cand[10:8];
      src_mask3 = cand3[7:0];
      is_load3  = cand3[15];
      dst3      = cand3[10:8];
   end

   typedef struct {
      logic        sel;
      logic        rst;
      logic        iv;
      logic [15:0] instr;
      logic        st;
      logic        fl;
      logic [15:0] e_out;
      logic        e_iss;
      logic        e_haz;
      logic        e_fo;
      logic        e_hold;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic sel, logic r, logic iv, logic [15:0] ins,
                               logic st, logic fl, logic [15:0] eo, logic ei,
                               logic eh, logic ef, logic ehold);
      vec_t v;
      v.sel = sel; v.rst = r; v.iv = iv; v.instr = ins; v.st = st; v.fl = fl;
      v.e_out = eo; v.e_iss = ei; v.e_haz = eh; v.e_fo = ef; v.e_hold = ehold;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                       input logic st, input logic fl);
      rst = r; instr_valid = iv; instr_in = ins; stall = st; flush = fl;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // LOAD_LAT=1 instance
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,0,0)); // reset state
      vecs.push_back(mk(0,0,1,16'h8300,0,0, 16'h8300,1,0,0,0)); // load r3
      vecs.push_back(mk(0,0,1,16'h0108,0,0, 16'h0800,0,1,0,0)); // consumer blocked
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0108,1,0,0,1)); // replay issues
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0204,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h8300,0,0, 16'h8300,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h0108,0,0, 16'h0800,0,1,0,0)); // capture
      vecs.push_back(mk(0,0,1,16'h0204,0,1, 16'h0800,0,0,1,1)); // flush with replay
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0800,0,0,1,0)); // window 2nd cycle
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0204,1,0,0,0)); // fetch accepted
      vecs.push_back(mk(0,0,1,16'h8300,0,0, 16'h8300,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h0108,0,1, 16'h0800,0,1,1,0)); // flush + hazard
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,1,0)); // no capture
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,0,0));
      vecs.push_back(mk(0,0,1,16'h8100,0,0, 16'h8100,1,0,0,0)); // load r1
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,1,16'h0202,1,0, 16'h0800,0,1,0,0)); // stalled, sb holds
      vecs.push_back(mk(0,0,1,16'h0202,0,0, 16'h0800,0,1,0,0)); // first unstalled
      vecs.push_back(mk(0,0,1,16'h0202,0,0, 16'h0202,1,0,0,1));
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,0,0));
      vecs.push_back(mk(0,0,1,16'h0204,1,1, 16'h0800,0,0,1,0)); // flush during stall
      vecs.push_back(mk(0,0,1,16'h0204,1,0, 16'h0800,0,0,1,0));
      vecs.push_back(mk(0,0,1,16'h0204,1,0, 16'h0800,0,0,1,0));
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0800,0,0,1,0));
      vecs.push_back(mk(0,0,1,16'h0204,0,0, 16'h0204,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h8300,0,0, 16'h8300,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h0108,0,0, 16'h0800,0,1,0,0));
      vecs.push_back(mk(0,1,0,16'h0000,0,1, 16'h0800,0,0,1,1)); // rst + flush
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,0,0)); // window cleared
      vecs.push_back(mk(0,0,1,16'h8300,0,0, 16'h8300,1,0,0,0));
      vecs.push_back(mk(0,0,1,16'h0108,0,0, 16'h0800,0,1,0,0));
      vecs.push_back(mk(0,1,0,16'h0000,0,0, 16'h0108,1,0,0,1)); // rst with replay
      vecs.push_back(mk(0,0,0,16'h0000,0,0, 16'h0800,0,0,0,0)); // replay cleared
      // LOAD_LAT=3 instance
      vecs.push_back(mk(1,1,0,16'h0000,0,0, 16'h0800,0,0,0,0));
      vecs.push_back(mk(1,0,1,16'h8500,0,0, 16'h8500,1,0,0,0)); // load r5
      vecs.push_back(mk(1,0,1,16'h0120,0,0, 16'h0800,0,1,0,0)); // bubble 1
      vecs.push_back(mk(1,0,1,16'h0104,0,0, 16'h0800,0,1,0,1)); // bubble 2
      vecs.push_back(mk(1,0,1,16'h0104,0,0, 16'h0800,0,1,0,1)); // bubble 3
      vecs.push_back(mk(1,0,1,16'h0104,0,0, 16'h0120,1,0,0,1)); // issue
      vecs.push_back(mk(1,0,1,16'h8500,0,0, 16'h8500,1,0,0,0));
      vecs.push_back(mk(1,0,1,16'h0104,0,0, 16'h0104,1,0,0,0)); // r2 consumer, no bubble
      vecs.push_back(mk(1,1,0,16'h0000,0,0, 16'h0800,0,0,0,0)); // rst clears sb
      vecs.push_back(mk(1,0,1,16'h0120,0,0, 16'h0120,1,0,0,0));

      rst = 1'b1; instr_valid = 1'b0; instr_in = 16'h0000; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].iv, vecs[i].instr, vecs[i].st, vecs[i].fl);
         if (vecs[i].sel == 1'b0) begin
            chk("instr_out",  i, out,          vecs[i].e_out);
            chk("issue",      i, 16'(iss),     16'(vecs[i].e_iss));
            chk("hazard",     i, 16'(haz),     16'(vecs[i].e_haz));
            chk("flush_out",  i, 16'(fo),      16'(vecs[i].e_fo));
            chk("fetch_hold", i, 16'(hold),    16'(vecs[i].e_hold));
         end else begin
            chk("lat3_instr_out",  i, out3,       vecs[i].e_out);
            chk("lat3_issue",      i, 16'(iss3),  16'(vecs[i].e_iss));
            chk("lat3_hazard",     i, 16'(haz3),  16'(vecs[i].e_haz));
            chk("lat3_flush_out",  i, 16'(fo3),   16'(vecs[i].e_fo));
            chk("lat3_fetch_hold", i, 16'(hold3), 16'(vecs[i].e_hold));
         end
         adv();
      end

      // Statistics: 3 unstalled hazard cycles (one stalled hazard excluded), 2 flushes
      step(1,0,16'h0000,0,0); adv();
      step(0,1,16'h8300,0,0);
      chk("stall_cnt_reset", 100, scnt, 16'h0000);
      chk("flush_cnt_reset", 100, fcnt, 16'h0000);
      adv();
      step(0,1,16'h0108,0,0); chk("stats_hazard", 101, 16'(haz), 16'h0001); adv();
      step(0,1,16'h0204,0,0); adv();
      step(0,1,16'h8300,0,0); adv();
      step(0,1,16'h0108,1,0); chk("stats_stalled_hazard", 102, 16'(haz), 16'h0001); adv();
      step(0,1,16'h0108,0,0); adv();
      step(0,1,16'h0204,0,0); adv();
      step(0,1,16'h8300,0,0); adv();
      step(0,1,16'h0108,0,0); adv();
      step(0,0,16'h0000,0,1); adv();
      step(0,0,16'h0000,0,1); adv();
      step(0,0,16'h0000,0,0);
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cnt", 103, scnt, 16'd3);
      chk("flush_cnt", 103, fcnt, 16'd2);
`else
      chk("stall_cnt", 103, scnt, 16'h0000);
      chk("flush_cnt", 103, fcnt, 16'h0000);
`endif
      adv();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
